serial_word_tx: RTL and testbench
=================================

# serial_word_tx

Upstream feeder for the serial pattern detector. Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on the single-bit serial line `j` that the detector samples every cycle. A one-entry holding register lets consecutive words stream with no idle bit between them. An optional parity bit is appended after each word.

## Interface

Parameters:
- `WIDTH`, 8: word width in bits. Legal range is 2 to 16.

Ports:
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst`  in  1  reset. Synchronous and active-low: the block resets on a rising `clk` edge while `rst`=0.
- `din`  in  WIDTH  parallel word to transmit.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  block can accept a word this cycle.
- `j`  out  1  serial bit stream to the detector. Idle level is 0.
- `j_valid`  out  1  `j` carries a data or parity bit this cycle.
- `word_done`  out  1  one-cycle pulse that coincides with the final serial bit of each word.
- `busy`  out  1  shifter is active or the holding register is occupied.

## Operation

Handshake:
- A word is accepted on a rising edge where `din_valid`=1 and `din_ready`=1.
- `din_ready` = `rst` AND NOT `hold_full`. It is combinational from registered state and does not depend on `din_valid`.
- When `din_valid`=1 and `din_ready`=0, `din` is ignored. The source must hold it.

Shift-register FSM:
- States are IDLE, SHIFT, and PAR. PAR exists only with the parity macro.
- Internal registers are shift register `sr[WIDTH-1:0]`, bit counter `cnt` (clog2(WIDTH) bits), holding register `hold`, `hold_full`, and, with parity, running parity `par`.

Load source, evaluated at each edge where the shifter is free:
- The shifter is free when it is in IDLE, or on the edge that ends the current word's final bit.
- If `hold_full`=1, load from `hold`, clear `hold_full`, then capture any accepted `din` into `hold`.
- Otherwise, if a word is accepted on this edge, load it directly into the shifter.
- Otherwise, go to IDLE.

When the shifter is busy, an accepted word goes to `hold` and `hold_full` is set.

IDLE:
- `j`=0, `j_valid`=0.
- On load, go to SHIFT with `sr`=word and `cnt`=0.

SHIFT:
- `j`=`sr[WIDTH-1]`, `j_valid`=1.
- Each edge: `sr` shifts left by one (0 enters at the LSB) and `cnt` increments.
- The final bit is at `cnt`=WIDTH-1.
- After the final bit, go to PAR if enabled; otherwise apply the load rule.

PAR:
- One cycle with `j`=`par`, `j_valid`=1.
- Then apply the load rule.

Outputs:
- `word_done`=1 exactly in the cycle the last bit is presented: the final SHIFT bit, or the PAR bit when parity is enabled.
- `busy` = (state != IDLE) OR `hold_full`.

Reset behaviour:
- Reset has priority over everything, including mid-word.
- On reset: state=IDLE, `sr`=0, `cnt`=0, `hold_full`=0, `par`=0.
- Outputs in the first cycle after reset: `j`=0, `j_valid`=0, `word_done`=0, `busy`=0.
- Any partial word or held word is discarded and is never resumed.
- While `rst`=0, `din_ready`=0, so no word is accepted on a reset edge.

## Timing

- Latency: a word accepted at edge k, with the shifter free, puts its MSB on `j` in cycle k+1 and its LSB in cycle k+WIDTH.
- Throughput: one bit per clock, continuous.
  - Without parity: WIDTH cycles per word.
  - With parity: WIDTH+1 cycles per word.
- There are no gaps between words while `hold` is kept filled.
- Backpressure: with the shifter busy and `hold_full`=1, `din_ready` stays 0 until the edge that starts the held word. `din_ready` is 1 in the cycle after that edge.
- Simultaneous events:
  - Accepting on the final-bit edge with `hold` empty produces a gapless transition; the new MSB appears in the next cycle.
  - Accepting on the final-bit edge with `hold` full is allowed: `hold` drains into the shifter and captures `din` on the same edge.

## Configuration

- `SERIAL_WORD_TX_PARITY_EN` defined:
  - The PAR state is compiled in.
  - After each word's LSB, one even-parity bit is sent (the XOR of all WIDTH data bits).
  - `word_done` moves to the parity cycle.
  - Word period is WIDTH+1.
- Undefined:
  - No PAR state and no `par` register.
  - Word period is WIDTH.

## Test plan

- Reset then idle: hold `rst`=0 for 2 edges, then release with `din_valid`=0 → `j`=0, `j_valid`=0, `busy`=0, `din_ready`=1.
- Single word, WIDTH=5, `din`=5'b10010, no parity → `j` = 1,0,0,1,0 in cycles k+1..k+5; `j_valid` high for those 5 cycles; `word_done` only at k+5; then idle 0.
- Back-to-back, WIDTH=8, 8'hA5 then 8'h3C with `din_valid` held high → 16 consecutive valid bits 10100101 00111100, no gap. `din_ready` drops for 7 cycles after the second accept, then reasserts in the cycle after 8'h3C moves into the shifter.
- Backpressure with 3 words presented continuously → the third word is stalled while `hold_full`=1, then sent intact. The stream has 24 contiguous bits.
- Reset mid-word: assert `rst`=0 during bit 3 of 8'hFF with a word held → in the next cycle `j`=0, `j_valid`=0, `busy`=0. Neither the partial word nor the held word appears after release.
- Parity (macro defined), WIDTH=8: 8'hA5 → data bits then parity bit 0; 8'h07 → data bits then parity bit 1. `word_done` is on each parity cycle and the period is 9 cycles.

Source files
------------

// File: rtl/serial_word_tx.sv
// ============================================================================
//  Module   : serial_word_tx
//  Function : Parallel-to-serial word transmitter, MSB first, one bit per clock,
//             with a one-entry holding register for gapless streaming.
//             Define SERIAL_WORD_TX_PARITY_EN to append an even-parity bit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_word_tx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             j,
   output logic             j_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SERIAL_WORD_TX_PARITY_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PAR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
`ifdef SERIAL_WORD_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   logic accept;
   logic last_bit;
   logic free;

   assign din_ready = rst & ~hold_full_q;
   assign accept    = din_valid & din_ready;
   assign last_bit  = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

`ifdef SERIAL_WORD_TX_PARITY_EN
   assign free = (state_q == ST_IDLE) || (state_q == ST_PAR);
`else
   assign free = (state_q == ST_IDLE) || last_bit;
`endif

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par_d       = par_q;
`endif

      if (state_q == ST_SHIFT) begin
         sr_d  = {sr_q[WIDTH-2:0], 1'b0};
         cnt_d = cnt_q + 1'b1;
`ifdef SERIAL_WORD_TX_PARITY_EN
         par_d = par_q ^ sr_q[WIDTH-1];
         if (last_bit) begin
            state_d = ST_PAR;
         end
`endif
      end

      // The held word always wins the shifter; a fresh word then refills hold.
      if (free) begin
         if (hold_full_q) begin
            state_d     = ST_SHIFT;
            sr_d        = hold_q;
            cnt_d       = '0;
            hold_full_d = accept;
            if (accept) begin
               hold_d = din;
            end
`ifdef SERIAL_WORD_TX_PARITY_EN
            par_d = 1'b0;
`endif
         end else if (accept) begin
            state_d = ST_SHIFT;
            sr_d    = din;
            cnt_d   = '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par_d   = 1'b0;
`endif
         end else begin
            state_d = ST_IDLE;
         end
      end else if (accept) begin
         hold_d      = din;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
`ifdef SERIAL_WORD_TX_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   always_comb begin
      j         = 1'b0;
      j_valid   = 1'b0;
      word_done = 1'b0;
      case (state_q)
         ST_SHIFT: begin
            j       = sr_q[WIDTH-1];
            j_valid = 1'b1;
`ifndef SERIAL_WORD_TX_PARITY_EN
            word_done = last_bit;
`endif
         end
`ifdef SERIAL_WORD_TX_PARITY_EN
         ST_PAR: begin
            j         = par_q;
            j_valid   = 1'b1;
            word_done = 1'b1;
         end
`endif
         default: begin
            j         = 1'b0;
            j_valid   = 1'b0;
            word_done = 1'b0;
         end
      endcase
   end

   assign busy = (state_q != ST_IDLE) || hold_full_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_word_tx.sv
// ============================================================================
//  Module   : tb_serial_word_tx
//  Function : Directed self-checking bench for serial_word_tx (WIDTH 5 and 8).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_word_tx;

`ifdef SERIAL_WORD_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int P8 = 8 + PB;
   localparam int P5 = 5 + PB;

   logic       clk;
   logic       rst;
   logic [7:0] din8;
   logic       v8;
   logic       rdy8, j8, jv8, wd8, busy8;
   logic [4:0] din5;
   logic       v5;
   logic       rdy5, j5, jv5, wd5, busy5;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   serial_word_tx #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .din(din8), .din_valid(v8), .din_ready(rdy8),
      .j(j8), .j_valid(jv8), .word_done(wd8), .busy(busy8)
   );

   serial_word_tx #(.WIDTH(5)) u5 (
      .clk(clk), .rst(rst), .din(din5), .din_valid(v5), .din_ready(rdy5),
      .j(j5), .j_valid(jv5), .word_done(wd5), .busy(busy5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Data bits MSB first, then (position == width) the even parity of the word.
   function automatic logic exp_bit(input logic [15:0] w, input int width, input int pos);
      logic p;
      p = 1'b0;
      if (pos < width) return w[width-1-pos];
      for (int b = 0; b < width; b++) p = p ^ w[b];
      return p;
   endfunction

   task automatic chk_idle8(input string tag);
      chk({tag, " j"}, {15'd0, j8}, 16'd0);
      chk({tag, " j_valid"}, {15'd0, jv8}, 16'd0);
      chk({tag, " busy"}, {15'd0, busy8}, 16'd0);
      chk({tag, " word_done"}, {15'd0, wd8}, 16'd0);
   endtask

   // Presents n words back to back on the 8-bit instance and checks the stream.
   task automatic run_stream(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input int n);
      logic [7:0] w [3];
      int         idx;
      logic       acc;
      logic       rdy_exp;
      w[0] = w0;
      w[1] = w1;
      w[2] = w2;
      chk({tag, " ready idle"}, {15'd0, rdy8}, 16'd1);
      din8 = w[0];
      v8   = 1'b1;
      tick();
      idx = 1;
      if (idx < n) din8 = w[idx];
      else v8 = 1'b0;
      for (int i = 0; i < n * P8; i++) begin
         rdy_exp = ((i % P8 == 0) && (i / P8 < n - 1)) || (i >= (n - 1) * P8);
         chk($sformatf("%s j_valid[%0d]", tag, i), {15'd0, jv8}, 16'd1);
         chk($sformatf("%s j[%0d]", tag, i), {15'd0, j8},
             {15'd0, exp_bit({8'd0, w[i / P8]}, 8, i % P8)});
         chk($sformatf("%s word_done[%0d]", tag, i), {15'd0, wd8},
             {15'd0, (i % P8) == (P8 - 1)});
         chk($sformatf("%s din_ready[%0d]", tag, i), {15'd0, rdy8}, {15'd0, rdy_exp});
         chk($sformatf("%s busy[%0d]", tag, i), {15'd0, busy8}, 16'd1);
         acc = v8 & rdy8;
         tick();
         if (acc) begin
            idx++;
            if (idx < n) din8 = w[idx];
            else v8 = 1'b0;
         end
      end
      chk_idle8({tag, " after"});
   endtask

   initial begin
      rst  = 1'b0;
      din8 = '0;
      v8   = 1'b0;
      din5 = '0;
      v5   = 1'b0;

      // Reset held for two edges, then released
      tick();
      tick();
      chk("reset din_ready8", {15'd0, rdy8}, 16'd0);
      chk("reset din_ready5", {15'd0, rdy5}, 16'd0);
      chk_idle8("reset");
      rst = 1'b1;
      tick();
      chk_idle8("post-reset");
      chk("post-reset din_ready8", {15'd0, rdy8}, 16'd1);
      chk("post-reset j5", {15'd0, j5}, 16'd0);
      chk("post-reset j_valid5", {15'd0, jv5}, 16'd0);
      chk("post-reset busy5", {15'd0, busy5}, 16'd0);
      chk("post-reset din_ready5", {15'd0, rdy5}, 16'd1);

      // Single 5-bit word 10010
      din5 = 5'b10010;
      v5   = 1'b1;
      tick();
      v5 = 1'b0;
      for (int i = 0; i < P5; i++) begin
         chk($sformatf("w5 j_valid[%0d]", i), {15'd0, jv5}, 16'd1);
         chk($sformatf("w5 j[%0d]", i), {15'd0, j5}, {15'd0, exp_bit(16'b10010, 5, i)});
         chk($sformatf("w5 word_done[%0d]", i), {15'd0, wd5}, {15'd0, i == P5 - 1});
         tick();
      end
      chk("w5 idle j", {15'd0, j5}, 16'd0);
      chk("w5 idle j_valid", {15'd0, jv5}, 16'd0);
      chk("w5 idle busy", {15'd0, busy5}, 16'd0);
      chk("w5 idle word_done", {15'd0, wd5}, 16'd0);

      // Back-to-back, backpressure with three words, lone odd-parity word
      run_stream("b2b", 8'hA5, 8'h3C, 8'h00, 2);
      run_stream("bp3", 8'hC3, 8'h96, 8'h0F, 3);
      run_stream("w07", 8'h07, 8'h00, 8'h00, 1);

      // Reset during bit 3 of 8'hFF with 8'h81 held
      din8 = 8'hFF;
      v8   = 1'b1;
      tick();
      din8 = 8'h81;
      tick();
      v8 = 1'b0;
      tick();
      tick();
      chk("mid busy", {15'd0, busy8}, 16'd1);
      chk("mid held din_ready", {15'd0, rdy8}, 16'd0);
      chk("mid bit3", {15'd0, j8}, 16'd1);
      rst = 1'b0;
      tick();
      chk_idle8("mid-reset");
      chk("mid-reset din_ready", {15'd0, rdy8}, 16'd0);
      rst = 1'b1;
      for (int i = 0; i < 2 * P8 + 2; i++) begin
         tick();
         chk($sformatf("discard j_valid[%0d]", i), {15'd0, jv8}, 16'd0);
         chk($sformatf("discard j[%0d]", i), {15'd0, j8}, 16'd0);
      end
      chk("discard busy", {15'd0, busy8}, 16'd0);
      chk("discard din_ready", {15'd0, rdy8}, 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
